// File: rtl/btn_step_pulse_if.sv
// Button-side bundle for btn_step_pulse: debounced level in, step strobe,
// repeat indication and press counter out.
interface btn_step_pulse_if #(
    parameter int CNT_W = 8
);
    logic             BTN_In;
    logic             Step_Pulse;
    logic             Held;
    logic [CNT_W-1:0] Press_Count;

    modport master (
        output BTN_In,
        input  Step_Pulse,
        input  Held,
        input  Press_Count
    );

    modport slave (
        input  BTN_In,
        output Step_Pulse,
        output Held,
        output Press_Count
    );
endinterface

// File: rtl/btn_step_pulse.sv
// Turns a debounced button level into single-cycle step pulses: one per
// press, followed by optional auto-repeat pulses while the button is held.
module btn_step_pulse #(
    parameter int HOLD_CYCLES   = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int REPEAT_EN     = 1,
    parameter int CNT_W         = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    btn_step_pulse_if.slave bus
);
    localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES);

    localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        LOCK,
        IDLE,
        WAIT_HOLD,
        REPEAT
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [TW-1:0]    timer;
    logic [TW-1:0]    timer_n;
    logic             s1;
    logic             s2;
    logic             step_pulse;
    logic             held;
    logic             pulse_n;
    logic             held_n;
    logic [CNT_W-1:0] press_count;

    // Two-flop synchroniser; resets to "pressed" so a held button is ignored until released.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= bus.BTN_In;
            s2 <= s1;
        end
    end

    // State, timer and registered outputs; the counter tracks every issued pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= LOCK;
            timer       <= '0;
            step_pulse  <= 1'b0;
            held        <= 1'b0;
            press_count <= '0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            step_pulse <= pulse_n;
            held       <= held_n;
            if (pulse_n) begin
                press_count <= press_count + 1'b1;
            end
        end
    end

    // Next state and timer; release is checked first so it beats any pulse on the same edge.
    always_comb begin
        state_n = state;
        timer_n = timer;
        case (state)
            LOCK: begin
                if (!s2) state_n = IDLE;
            end
            IDLE: begin
                if (s2) state_n = WAIT_HOLD;
            end
            WAIT_HOLD: begin
                if (!s2) begin
                    state_n = IDLE;
                end else if (REPEAT_EN != 0) begin
                    if (timer == HOLD_LAST) state_n = REPEAT;
                    else                    timer_n = timer + 1'b1;
                end
            end
            REPEAT: begin
                if (!s2)                        state_n = IDLE;
                else if (timer == REPEAT_LAST)  timer_n = '0;
                else                            timer_n = timer + 1'b1;
            end
            default: state_n = LOCK;
        endcase
        // Every state entry restarts the timer.
        if (state_n != state) timer_n = '0;
    end

    // Next values of the registered pulse and hold outputs.
    always_comb begin
        pulse_n = 1'b0;
        case (state)
            IDLE:      pulse_n = s2;
            WAIT_HOLD: pulse_n = s2 && (REPEAT_EN != 0) && (timer == HOLD_LAST);
            REPEAT:    pulse_n = s2 && (timer == REPEAT_LAST);
            default:   pulse_n = 1'b0;
        endcase
        held_n = (state_n == REPEAT);
    end

    assign bus.Step_Pulse  = step_pulse;
    assign bus.Held        = held;
    assign bus.Press_Count = press_count;
endmodule
